hazard_controller: RTL

Pipeline hazard and forwarding controller for the 5-stage LEGv8 core (IF/ID/EX/MEM/WB).
- Consumes the one-hot 11-bit opcode vector produced by the ID-stage instruction decoder, plus the raw ID instruction.
- Keeps a small in-flight scoreboard of EX/MEM/WB writers.
- Drives IF/ID stall, ID/EX bubble, IF/ID flush, and the EX-stage and ID-stage (CBZ) forwarding-mux selects.
- Keeps stall and flush performance counters.

---
 rtl/hazard_pkg.sv | 30 +++
 rtl/hazard_scoreboard.sv | 38 +++
 rtl/hazard_controller.sv | 131 +++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared opcode indices, forward selects and scoreboard entry type
package hazard_pkg;

  localparam int OP_ADDI = 0;
  localparam int OP_ADDS = 1;
  localparam int OP_AND  = 2;
  localparam int OP_B    = 3;
  localparam int OP_BLT  = 4;
  localparam int OP_CBZ  = 5;
  localparam int OP_EOR  = 6;
  localparam int OP_LDUR = 7;
  localparam int OP_LSR  = 8;
  localparam int OP_STUR = 9;
  localparam int OP_SUBS = 10;
  localparam int NOPS    = 11;

  localparam int REG_W = 5;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             is_load;
    logic             sets_flags;
  } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - EX/MEM/WB in-flight writer shift register
module hazard_scoreboard
  import hazard_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      bubble_i,
  input  sb_entry_t id_entry_i,
  output sb_entry_t ex_o,
  output sb_entry_t mem_o,
  output sb_entry_t wb_o
);

  sb_entry_t ex_q, mem_q, wb_q;
  sb_entry_t ex_d;

  always_comb begin
    ex_d = id_entry_i;
    if (bubble_i) ex_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  assign ex_o  = ex_q;
  assign mem_o = mem_q;
  assign wb_o  = wb_q;

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - LEGv8 load-use/CBZ stall, branch flush and forwarding control
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int NREG     = 32,
  parameter int ZERO_REG = 31,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [31:0]      id_instr,
  input  logic [NOPS-1:0]  id_check,
  input  logic             br_taken,
  output logic             stall_if_id,
  output logic             bubble_ex,
  output logic             flush_if_id,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             fwd_flags,
  output logic             cbz_fwd,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int RW = $clog2(NREG);

  sb_entry_t ex_e, mem_e, wb_e, id_entry;

  logic [RW-1:0] rd_f, rn_f, rm_f, b_src;
  logic is_addi, is_adds, is_and, is_blt, is_cbz, is_eor;
  logic is_ldur, is_lsr, is_stur, is_subs;
  logic writer, rn_used, rm_used, rt_used;
  logic load_use, stall;
  logic [1:0] fwd_a_d, fwd_b_d, fwd_a_q, fwd_b_q;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  // XZR reads are constant zero, so they never depend on an in-flight writer.
  function automatic logic hit(input logic [RW-1:0] src, input sb_entry_t e);
    return (src != RW'(ZERO_REG)) && e.valid && (e.rd == src);
  endfunction

  assign rd_f = id_instr[RW-1:0];
  assign rn_f = id_instr[5 +: RW];
  assign rm_f = id_instr[16 +: RW];

  assign is_addi = id_valid & id_check[OP_ADDI];
  assign is_adds = id_valid & id_check[OP_ADDS];
  assign is_and  = id_valid & id_check[OP_AND];
  assign is_blt  = id_valid & id_check[OP_BLT];
  assign is_cbz  = id_valid & id_check[OP_CBZ];
  assign is_eor  = id_valid & id_check[OP_EOR];
  assign is_ldur = id_valid & id_check[OP_LDUR];
  assign is_lsr  = id_valid & id_check[OP_LSR];
  assign is_stur = id_valid & id_check[OP_STUR];
  assign is_subs = id_valid & id_check[OP_SUBS];

  assign writer  = is_addi | is_adds | is_and | is_eor | is_ldur | is_lsr | is_subs;
  assign rn_used = is_addi | is_adds | is_and | is_eor | is_ldur | is_lsr | is_stur;
  assign rm_used = is_adds | is_and | is_eor | is_lsr | is_subs;
  assign rt_used = is_stur | is_cbz;

  always_comb begin
    id_entry            = '0;
    id_entry.valid      = writer;
    id_entry.rd         = rd_f;
    id_entry.is_load    = is_ldur;
    id_entry.sets_flags = is_adds | is_subs;
  end

  hazard_scoreboard u_sb (
    .clk        (clk),
    .reset      (reset),
    .bubble_i   (stall),
    .id_entry_i (id_entry),
    .ex_o       (ex_e),
    .mem_o      (mem_e),
    .wb_o       (wb_e)
  );

  // CBZ resolves in ID, so it needs its operand one stage earlier than EX consumers.
  assign load_use = ex_e.is_load & ((rn_used & hit(rn_f, ex_e)) |
                                    (rm_used & hit(rm_f, ex_e)) |
                                    (rt_used & hit(rd_f, ex_e)));
  assign stall = ~reset & (load_use | (is_cbz & hit(rd_f, ex_e)) |
                           (is_cbz & hit(rd_f, mem_e) & mem_e.is_load));

  assign b_src = is_stur ? rd_f : rm_f;

  always_comb begin
    fwd_a_d = FWD_RF;
    fwd_b_d = FWD_RF;
    if (id_valid) begin
      if (hit(rn_f, ex_e))       fwd_a_d = FWD_EXMEM;
      else if (hit(rn_f, mem_e)) fwd_a_d = FWD_MEMWB;
      if (hit(b_src, ex_e))       fwd_b_d = FWD_EXMEM;
      else if (hit(b_src, mem_e)) fwd_b_d = FWD_MEMWB;
    end
  end

  assign stall_cnt_d = stall_cnt_q + CNT_W'(stall);
  assign flush_cnt_d = flush_cnt_q + CNT_W'(flush_if_id);

  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_a_q     <= FWD_RF;
      fwd_b_q     <= FWD_RF;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fwd_a_q     <= stall ? FWD_RF : fwd_a_d;
      fwd_b_q     <= stall ? FWD_RF : fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_if_id = stall;
  assign bubble_ex   = stall;
  assign flush_if_id = ~reset & br_taken & ~stall;
  assign fwd_a       = fwd_a_q;
  assign fwd_b       = fwd_b_q;
  assign fwd_flags   = ~reset & is_blt & ex_e.valid & ex_e.sets_flags;
  assign cbz_fwd     = ~reset & is_cbz & hit(rd_f, mem_e) & ~mem_e.is_load;
  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

  logic unused_bits;
  assign unused_bits = ^{id_instr[31:21], id_instr[15:10], id_check[OP_B], wb_e};

endmodule
